// File: rtl/obstacle_scheduler_if.sv
// Obstacle scheduler bus: groups the game-control inputs, the external
// interval down-counter handshake and the scheduler status outputs.
//
// Signals:
//   frame_tick     one-cycle pulse per game frame
//   start          pulse, starts a game from IDLE or OVER
//   collision      level, dino/obstacle overlap
//   cnt_value[8:0] current value of the external down-counter
//   cnt_load       counter load strobe (counter takes cnt_load_value next edge)
//   cnt_load_value interval to load
//   cnt_dec        counter decrement enable
//   spawn          one-cycle obstacle spawn pulse
//   obstacle_type  type of the last spawned obstacle
//   level          current difficulty level
//   running        high while a game is in progress
//   game_over      high after a collision until restarted
//
// Modports:
//   master  game environment / counter side (drives the inputs)
//   slave   the scheduler itself
interface obstacle_scheduler_if;
  logic       frame_tick;
  logic       start;
  logic       collision;
  logic [8:0] cnt_value;
  logic       cnt_load;
  logic [8:0] cnt_load_value;
  logic       cnt_dec;
  logic       spawn;
  logic [1:0] obstacle_type;
  logic [2:0] level;
  logic       running;
  logic       game_over;

  modport master (
    output frame_tick, start, collision, cnt_value,
    input  cnt_load, cnt_load_value, cnt_dec, spawn,
    input  obstacle_type, level, running, game_over
  );

  modport slave (
    input  frame_tick, start, collision, cnt_value,
    output cnt_load, cnt_load_value, cnt_dec, spawn,
    output obstacle_type, level, running, game_over
  );
endinterface

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: sequences the external 9-bit obstacle interval
// down-counter. Loads it with a jittered spawn interval, forwards frame
// ticks as decrements while waiting, and emits a one-cycle spawn pulse with
// an obstacle type when the counter reaches zero. Difficulty rises every
// SPAWNS_PER_LEVEL spawns (saturating at MAX_LEVEL); a collision freezes
// the game in OVER until start.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   sched  obstacle_scheduler_if.slave (control inputs, counter handshake,
//          status outputs)
module obstacle_scheduler #(
  parameter int         BASE_INTERVAL    = 200,
  parameter int         MIN_INTERVAL     = 40,
  parameter int         LEVEL_STEP       = 16,
  parameter int         SPAWNS_PER_LEVEL = 8,
  parameter int         MAX_LEVEL        = 7,
  parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  obstacle_scheduler_if.slave  sched
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_SPAWN = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [7:0] SEED_EFF   = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [2:0] SPAWN_WRAP = 3'(SPAWNS_PER_LEVEL - 1);
  localparam logic [2:0] LEVEL_MAX  = 3'(MAX_LEVEL);

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] level_q, level_d;
  logic [2:0] spawn_cnt_q, spawn_cnt_d;
  logic [1:0] type_q, type_d;

  logic       cnt_load;
  logic [8:0] cnt_load_value;
  logic       cnt_dec;
  logic       spawn;
  logic       running;
  logic       game_over;

  // Per-level interval base, clamped at MIN_INTERVAL. Evaluated at
  // elaboration in signed int arithmetic, so the subtraction cannot wrap.
  logic [8:0] base_lut [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_base
    localparam int RAW     = BASE_INTERVAL - gi * LEVEL_STEP;
    localparam int CLAMPED = (RAW < MIN_INTERVAL) ? MIN_INTERVAL : RAW;
    assign base_lut[gi] = 9'(CLAMPED);
  end

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, advancing on every frame tick in all
  // states so the jitter sequence depends on how long the player survives.
  always_comb begin
    lfsr_d = lfsr_q;
    if (sched.frame_tick) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED_EFF;
      level_q     <= '0;
      spawn_cnt_q <= '0;
      type_q      <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      level_q     <= level_d;
      spawn_cnt_q <= spawn_cnt_d;
      type_q      <= type_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    spawn_cnt_d    = spawn_cnt_q;
    type_d         = type_q;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_dec        = 1'b0;
    spawn          = 1'b0;
    running        = 1'b0;
    game_over      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sched.start) begin
          state_d     = S_LOAD;
          level_d     = '0;
          spawn_cnt_d = '0;
        end
      end

      S_LOAD: begin
        running        = 1'b1;
        cnt_load       = 1'b1;
        cnt_load_value = base_lut[level_q] + {4'b0000, lfsr_q[4:0]};
        // cnt_value is still the old (possibly zero) count here; it is
        // deliberately not looked at.
        state_d        = sched.collision ? S_OVER : S_WAIT;
      end

      S_WAIT: begin
        running = 1'b1;
        cnt_dec = sched.frame_tick;
        if (sched.collision) begin
          state_d = S_OVER;
        end else if (sched.cnt_value == 9'd0) begin
          state_d = S_SPAWN;
          type_d  = lfsr_q[1:0];
        end
      end

      S_SPAWN: begin
        running = 1'b1;
        // The pulse is never retracted, so the spawn is counted even when a
        // collision sends us to OVER on the same edge.
        spawn   = 1'b1;
        if (spawn_cnt_q == SPAWN_WRAP) begin
          spawn_cnt_d = '0;
          if (level_q < LEVEL_MAX) begin
            level_d = level_q + 3'd1;
          end
        end else begin
          spawn_cnt_d = spawn_cnt_q + 3'd1;
        end
        state_d = sched.collision ? S_OVER : S_LOAD;
      end

      S_OVER: begin
        game_over = 1'b1;
        if (sched.start) begin
          state_d     = S_LOAD;
          level_d     = '0;
          spawn_cnt_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sched.cnt_load       = cnt_load;
  assign sched.cnt_load_value = cnt_load_value;
  assign sched.cnt_dec        = cnt_dec;
  assign sched.spawn          = spawn;
  assign sched.obstacle_type  = type_q;
  assign sched.level          = level_q;
  assign sched.running        = running;
  assign sched.game_over      = game_over;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Testbench for obstacle_scheduler. A bench-side down-counter model closes
// the load/decrement loop (with an optional override of the loaded value to
// shorten intervals), an independent LFSR model supplies expected jitter and
// obstacle types, and a queue holds the expected interval base of every
// counter load. A second instance with MIN_INTERVAL=100 exercises the clamp.
module tb_obstacle_scheduler;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  obstacle_scheduler_if bus ();
  obstacle_scheduler_if bus2 ();

  obstacle_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sched (bus)
  );

  obstacle_scheduler #(.MIN_INTERVAL(100)) dut_min (
    .clk   (clk),
    .rst_n (rst_n),
    .sched (bus2)
  );

  // External down-counter model.
  logic [8:0] cnt_m;
  logic       ovr_en;
  logic [8:0] ovr_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_m <= '0;
    end else if (bus.cnt_load) begin
      cnt_m <= ovr_en ? ovr_val : bus.cnt_load_value;
    end else if (bus.cnt_dec && cnt_m != 9'd0) begin
      cnt_m <= cnt_m - 9'd1;
    end
  end

  assign bus.cnt_value  = cnt_m;
  assign bus2.cnt_value = '0;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting left, seed A5.
  logic [7:0] lfsr_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m <= 8'hA5;
    end else if (bus.frame_tick) begin
      lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
  end

  logic [8:0] exp_q [$];
  int         checks;
  int         errors;
  int         s_done;
  int         decs_seen;
  logic [7:0] lfsr_prev;

  function automatic logic [8:0] base_of(input int spawns, input int min_iv);
    int lvl;
    int raw;
    lvl = spawns / 8;
    if (lvl > 7) lvl = 7;
    raw = 200 - 16 * lvl;
    if (raw < min_iv) raw = min_iv;
    return 9'(raw);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop and compare on every counter load, check the
  // obstacle type on every spawn.
  task automatic observe();
    logic [8:0] e;
    if (bus.cnt_load) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_load", 32'(bus.cnt_load), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_load_value", 32'(bus.cnt_load_value), 32'(e) + 32'(lfsr_m[4:0]));
      end
    end
    if (bus.cnt_dec) decs_seen++;
    if (bus.spawn) begin
      check("sb_spawn_type", 32'(bus.obstacle_type), 32'(lfsr_prev[1:0]));
    end
    lfsr_prev = lfsr_m;
  endtask

  // One clock cycle: drive inputs after the falling edge, sample 1 time unit
  // later. tick_mode: 0 none, 1 always, 2 while the counter is non-zero.
  // col_mode: 0 low, 1 high, 2 high only in a spawn cycle.
  task automatic cyc(input int tick_mode, input logic st, input int col_mode);
    @(negedge clk);
    bus.frame_tick = (tick_mode == 1) || (tick_mode == 2 && bus.cnt_value != 9'd0);
    bus.start      = st;
    bus.collision  = (col_mode == 1) || (col_mode == 2 && bus.spawn);
    #1;
    observe();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt_load"},  32'(bus.cnt_load), 32'd0);
    check({tag, "_load_val"},  32'(bus.cnt_load_value), 32'd0);
    check({tag, "_cnt_dec"},   32'(bus.cnt_dec), 32'd0);
    check({tag, "_spawn"},     32'(bus.spawn), 32'd0);
    check({tag, "_type"},      32'(bus.obstacle_type), 32'd0);
    check({tag, "_level"},     32'(bus.level), 32'd0);
    check({tag, "_running"},   32'(bus.running), 32'd0);
    check({tag, "_game_over"}, 32'(bus.game_over), 32'd0);
  endtask

  task automatic run_spawns(input int target);
    int budget;
    for (int k = s_done + 1; k <= target; k++) exp_q.push_back(base_of(k, 40));
    budget = 0;
    while (s_done < target && budget < 10 * target + 50) begin
      cyc(1, 1'b0, 0);
      if (bus.spawn) s_done++;
      budget++;
    end
    check("spawn_budget", 32'(s_done), 32'(target));
  endtask

  initial begin
    int zero_cyc;
    int spawn_cyc;
    int n2;
    logic [1:0] saved_type;

    checks = 0;
    errors = 0;
    s_done = 0;
    decs_seen = 0;
    lfsr_prev = 8'hA5;
    bus.frame_tick = 1'b0;
    bus.start = 1'b0;
    bus.collision = 1'b0;
    bus2.frame_tick = 1'b0;
    bus2.start = 1'b0;
    bus2.collision = 1'b0;
    ovr_en = 1'b0;
    ovr_val = '0;
    rst_n = 1'b0;

    // Reset state.
    cyc(0, 1'b0, 0);
    cyc(0, 1'b0, 0);
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc(0, 1'b0, 0);
    check("idle_running", 32'(bus.running), 32'd0);

    // First load: 200 + seed jitter 5, counter model overridden to 3.
    exp_q.push_back(base_of(0, 40));
    s_done = 0;
    ovr_en = 1'b1;
    ovr_val = 9'd3;
    cyc(0, 1'b1, 0);
    cyc(1, 1'b0, 0);
    check("first_load_strobe", 32'(bus.cnt_load), 32'd1);
    check("first_load_205", 32'(bus.cnt_load_value), 32'd205);
    check("first_load_level", 32'(bus.level), 32'd0);
    check("first_load_running", 32'(bus.running), 32'd1);
    check("tick_in_load_no_dec", 32'(bus.cnt_dec), 32'd0);

    // Count down 3, spawn one cycle after zero, reload after spawn.
    exp_q.push_back(base_of(1, 40));
    decs_seen = 0;
    zero_cyc = -1;
    spawn_cyc = -1;
    for (int i = 0; i < 20 && spawn_cyc < 0; i++) begin
      cyc(2, 1'b0, 0);
      if (bus.spawn) spawn_cyc = i;
      else if (zero_cyc < 0 && bus.cnt_value == 9'd0) zero_cyc = i;
    end
    check("dec_pulses", 32'(decs_seen), 32'd3);
    check("spawn_after_zero", 32'(spawn_cyc), 32'(zero_cyc + 1));
    s_done = 1;
    ovr_val = 9'd1;
    cyc(0, 1'b0, 0);
    check("reload_after_spawn", 32'(bus.cnt_load), 32'd1);

    // Difficulty ramp.
    run_spawns(8);
    cyc(0, 1'b0, 0);
    check("level_after_8", 32'(bus.level), 32'd1);
    check("base_level1", 32'(bus.cnt_load_value) - 32'(lfsr_m[4:0]), 32'd184);
    run_spawns(56);
    cyc(0, 1'b0, 0);
    check("level_after_56", 32'(bus.level), 32'd7);
    check("base_level7", 32'(bus.cnt_load_value) - 32'(lfsr_m[4:0]), 32'd88);
    run_spawns(64);
    ovr_val = 9'd50;
    cyc(0, 1'b0, 0);
    check("level_sat_64", 32'(bus.level), 32'd7);
    check("base_sat_64", 32'(bus.cnt_load_value) - 32'(lfsr_m[4:0]), 32'd88);

    // Collision in WAIT; start ignored while running.
    cyc(1, 1'b1, 0);
    check("wait_dec", 32'(bus.cnt_dec), 32'd1);
    cyc(0, 1'b0, 0);
    check("start_ignored_running", 32'(bus.running), 32'd1);
    check("start_ignored_no_load", 32'(bus.cnt_load), 32'd0);
    cyc(1, 1'b1, 1);
    check("collision_cycle_still_wait", 32'(bus.cnt_dec), 32'd1);
    cyc(1, 1'b0, 0);
    check("over_game_over", 32'(bus.game_over), 32'd1);
    check("over_cnt_dec", 32'(bus.cnt_dec), 32'd0);
    check("over_cnt_load", 32'(bus.cnt_load), 32'd0);
    check("over_spawn", 32'(bus.spawn), 32'd0);
    check("over_running", 32'(bus.running), 32'd0);
    check("over_level", 32'(bus.level), 32'd7);
    cyc(1, 1'b0, 0);
    check("over_holds", 32'(bus.game_over), 32'd1);
    check("sb_drained_over", 32'(exp_q.size()), 32'd0);

    // Restart, reach level 3, collide in the spawn cycle.
    exp_q.push_back(base_of(0, 40));
    s_done = 0;
    ovr_val = 9'd1;
    cyc(0, 1'b1, 0);
    cyc(0, 1'b0, 0);
    check("restart_level0", 32'(bus.level), 32'd0);
    check("restart_load", 32'(bus.cnt_load), 32'd1);
    run_spawns(24);
    spawn_cyc = -1;
    saved_type = 2'b00;
    for (int i = 0; i < 20 && spawn_cyc < 0; i++) begin
      cyc(1, 1'b0, 2);
      if (bus.spawn) begin
        spawn_cyc = i;
        saved_type = bus.obstacle_type;
      end
    end
    check("spawn_with_collision", 32'(bus.collision), 32'd1);
    cyc(0, 1'b0, 0);
    check("spawn_col_over", 32'(bus.game_over), 32'd1);
    check("spawn_col_no_load", 32'(bus.cnt_load), 32'd0);
    check("spawn_col_no_spawn", 32'(bus.spawn), 32'd0);
    check("spawn_col_level3", 32'(bus.level), 32'd3);
    check("type_held", 32'(bus.obstacle_type), 32'(saved_type));

    // Start from OVER at level 3: level clears, LFSR keeps running.
    exp_q.push_back(base_of(0, 40));
    s_done = 0;
    ovr_val = 9'd50;
    cyc(0, 1'b1, 0);
    cyc(0, 1'b0, 0);
    check("restart2_level0", 32'(bus.level), 32'd0);
    check("jitter_not_reseeded", 32'(bus.cnt_load_value) - 32'd200, 32'(lfsr_m[4:0]));

    // Asynchronous reset in the middle of WAIT.
    cyc(1, 1'b0, 0);
    check("pre_reset_running", 32'(bus.running), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    cyc(0, 1'b0, 0);
    rst_n = 1'b1;
    cyc(0, 1'b0, 0);
    check("post_reset_idle", 32'(bus.running), 32'd0);

    // MIN_INTERVAL=100 instance: counter tied to zero, no ticks (jitter 5).
    bus2.start = 1'b1;
    cyc(0, 1'b0, 0);
    bus2.start = 1'b0;
    check("min_first_load", 32'(bus2.cnt_load_value), 32'd205);
    n2 = 0;
    for (int i = 0; i < 400 && n2 < 56; i++) begin
      cyc(0, 1'b0, 0);
      if (bus2.spawn) n2++;
    end
    check("min_spawn_budget", 32'(n2), 32'd56);
    cyc(0, 1'b0, 0);
    check("min_level7", 32'(bus2.level), 32'd7);
    check("min_clamp_105", 32'(bus2.cnt_load_value), 32'd105);

    check("sb_final_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Game-level controller that sequences the 9-bit obstacle interval down-counter in the dino-obstacle design. It loads the counter with a randomised spawn interval, gates its decrement on the frame tick, and emits a one-cycle spawn pulse with an obstacle type when the counter reaches zero. It raises difficulty every fixed number of spawns and freezes on collision until restarted. The counter itself is external, so this block is its only load/decrement master.

## Interface
- `BASE_INTERVAL`, 200: frame ticks between spawns at level 0, before jitter.
- `MIN_INTERVAL`, 40: floor on the non-jitter part of the interval.
- `LEVEL_STEP`, 16: interval reduction per level.
- `SPAWNS_PER_LEVEL`, 8: spawns per level increment.
- `MAX_LEVEL`, 7: level saturation value.
- `LFSR_SEED`, 8'hA5: LFSR reset value. A seed of 0 is replaced by 8'h01.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse per game frame.
- `start`  in  1  pulse; starts the game from IDLE or OVER.
- `collision`  in  1  level; dino/obstacle overlap.
- `cnt_value`  in  9  current value of the external down-counter.
- `cnt_load`  out  1  counter load strobe; the counter takes `cnt_load_value` on the next edge.
- `cnt_load_value`  out  9  interval to load.
- `cnt_dec`  out  1  counter decrement enable.
- `spawn`  out  1  one-cycle obstacle spawn pulse.
- `obstacle_type`  out  2  type of the spawned obstacle; valid while `spawn`=1 and held until the next spawn.
- `level`  out  3  current difficulty level.
- `running`  out  1  high in LOAD, WAIT and SPAWN.
- `game_over`  out  1  high in OVER.

## Operation
- State machine, Moore outputs:
  - IDLE: `start` -> LOAD.
  - LOAD: `cnt_load`=1 -> WAIT.
  - WAIT: `cnt_dec`=`frame_tick`; `cnt_value`==0 -> SPAWN.
  - SPAWN: `spawn`=1 -> LOAD.
  - OVER: `game_over`=1; `start` -> LOAD.
- Transition priority:
  - In LOAD, WAIT and SPAWN, `collision`=1 -> OVER. This beats every other transition.
  - The pulse is not retracted: SPAWN with `collision` still outputs `spawn`=1 for that cycle, then goes to OVER.
  - `start` is ignored in LOAD, WAIT and SPAWN.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifting left, new bit = l[7]^l[5]^l[4]^l[3].
  - Advances on every `frame_tick` in all states. It is never cleared by `start`.
- Interval, computed combinationally in LOAD from the current LFSR and level:
  - base = max(MIN_INTERVAL, BASE_INTERVAL − level×LEVEL_STEP), computed without underflow.
  - `cnt_load_value` = base + lfsr[4:0].
  - Parameters must keep BASE_INTERVAL+31 ≤ 511.
- `obstacle_type` = lfsr[1:0], registered on entry to SPAWN.
- Spawn counting:
  - A 3-bit spawn counter increments in SPAWN.
  - When it equals SPAWNS_PER_LEVEL−1, it clears and `level` increments, saturating at MAX_LEVEL.
- On `start` from OVER or IDLE: `level` and the spawn counter clear. The LFSR keeps its value.
- `cnt_load_value` reads 0 outside LOAD. `cnt_dec`=0 outside WAIT.

## Timing
- Reset values:
  - state IDLE; all outputs 0; `level`=0; spawn counter 0; LFSR=`LFSR_SEED`.
- Latency:
  - `start` to `cnt_load`: 1 cycle.
  - LOAD to WAIT: 1 cycle. The counter holds the new value in the first WAIT cycle.
  - `cnt_value`==0 seen in WAIT to `spawn`: 1 cycle.
  - SPAWN to the next `cnt_load`: 1 cycle.
- Spawn period: interval frame ticks plus 3 clock cycles.
- `frame_tick` during LOAD or SPAWN is not forwarded as a decrement.
- The zero check uses `cnt_value` only in WAIT. A stale zero seen in LOAD is ignored.
- `collision` is sampled each edge. OVER is entered the cycle after it is seen high, and `cnt_dec` drops immediately.
- Reset asserted mid-game: asynchronous return to the reset values, with no spawn pulse.

## Test plan
- Reset, no ticks, `start` pulse -> `cnt_load`=1 with `cnt_load_value`=205 (200+5), `level`=0, `running`=1 the next cycle.
- Bench counter model loaded with 3 and ticks applied -> exactly 3 `cnt_dec` pulses, `spawn` 1 cycle after `cnt_value`==0, then `cnt_load` on the following cycle.
- 8 completed spawns -> `level`=1 and the next interval base is 184. 56 spawns -> `level` saturates at 7 and stays 7 with base 88. With MIN_INTERVAL=100, level 7 base clamps to 100.
- `collision` asserted in WAIT -> `game_over`=1 next cycle, `cnt_dec`/`cnt_load`/`spawn` stay 0, and `start` is ignored until OVER is reached.
- `collision` in the same cycle as SPAWN -> `spawn`=1 for that cycle, then OVER, with no `cnt_load`.
- `start` from OVER at `level`=3 -> `level`=0, LFSR not reseeded (`cnt_load_value` jitter equals the current lfsr[4:0]). `rst_n` low mid-WAIT -> all outputs 0 immediately.
